// File: rtl/noc_pe_injector.sv
// Mesh NoC processing-element interface: injects sequence-numbered flits toward a
// configured destination and checks the destination and per-source order of received flits.
`timescale 1ns/1ps
module noc_pe_injector #(
    parameter int N_NODES = 4,
    parameter int NODE_ID = 0,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8,
    parameter int GAP     = 0,
    localparam int ADDR_W = (N_NODES > 1) ? $clog2(N_NODES) : 1,
    localparam int FLIT_W = 2 * ADDR_W + DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_dest,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              cfg_ready,
    output logic              cfg_err,
    input  logic              block_all_paths,
    output logic [FLIT_W-1:0] tx_flit,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              done,
    input  logic [FLIT_W-1:0] rx_flit,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic [CNT_W-1:0]  rx_count,
    output logic              rx_err
);

    localparam logic [ADDR_W-1:0] MY_ADDR = ADDR_W'(NODE_ID);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  dest_reg;
    logic [DATA_W-1:0]  seq_reg;
    logic [CNT_W-1:0]   remaining_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic               cfg_err_reg;

    logic cfg_bad, cfg_take, xfer, last_flit, gap_end;

    assign cfg_bad   = (cfg_dest == MY_ADDR) || (32'(cfg_dest) >= N_NODES);
    assign cfg_take  = (state_reg == S_IDLE) && cfg_valid && !cfg_bad;
    assign xfer      = (state_reg == S_SEND) && tx_ready && !block_all_paths;
    assign last_flit = (remaining_reg == CNT_W'(1));
    assign gap_end   = (gap_cnt_reg == GAP_W'(GAP - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (cfg_take) begin
                    state_next = (cfg_count == '0) ? S_DONE : S_SEND;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (last_flit) begin
                        state_next = S_DONE;
                    end else if (GAP == 0) begin
                        state_next = S_SEND;
                    end else begin
                        state_next = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_end) begin
                    state_next = S_SEND;
                end
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Flit is only driven while a send is active so the port reads zero when idle.
    always_comb begin
        cfg_ready = (state_reg == S_IDLE);
        tx_valid  = (state_reg == S_SEND) && !block_all_paths;
        done      = (state_reg == S_DONE);
        tx_flit   = '0;
        if (state_reg == S_SEND) begin
            tx_flit = {MY_ADDR, dest_reg, seq_reg};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dest_reg      <= '0;
            seq_reg       <= '0;
            remaining_reg <= '0;
            gap_cnt_reg   <= '0;
            cfg_err_reg   <= 1'b0;
        end else begin
            cfg_err_reg <= (state_reg == S_IDLE) && cfg_valid && cfg_bad;
            if (cfg_take) begin
                dest_reg      <= cfg_dest;
                remaining_reg <= cfg_count;
                seq_reg       <= '0;
            end
            if (xfer) begin
                seq_reg       <= seq_reg + DATA_W'(1);
                remaining_reg <= remaining_reg - CNT_W'(1);
            end
            if (state_reg == S_GAP) begin
                gap_cnt_reg <= gap_end ? '0 : gap_cnt_reg + GAP_W'(1);
            end
        end
    end

    assign cfg_err = cfg_err_reg;

    // Receive path: field extraction and per-source expected sequence table.
    logic [ADDR_W-1:0]          rx_src, rx_dst;
    logic [DATA_W-1:0]          rx_payload, expect_sel;
    logic                       rx_dst_ok;
    logic [N_NODES*DATA_W-1:0]  expect_flat;
    logic [DATA_W-1:0]          rx_data_reg;
    logic [CNT_W-1:0]           rx_count_reg;
    logic                       rx_err_reg;

    assign rx_src     = rx_flit[FLIT_W-1 -: ADDR_W];
    assign rx_dst     = rx_flit[DATA_W +: ADDR_W];
    assign rx_payload = rx_flit[DATA_W-1:0];
    assign rx_dst_ok  = (rx_dst == MY_ADDR);

    generate
        for (genvar gi = 0; gi < N_NODES; gi++) begin : g_expect
            logic [DATA_W-1:0] expect_reg;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    expect_reg <= '0;
                end else if (rx_valid && rx_dst_ok && (rx_src == ADDR_W'(gi))) begin
                    expect_reg <= rx_payload + DATA_W'(1);
                end
            end
            assign expect_flat[gi*DATA_W +: DATA_W] = expect_reg;
        end
    endgenerate

    always_comb begin
        expect_sel = '0;
        for (int i = 0; i < N_NODES; i++) begin
            if (rx_src == ADDR_W'(i)) begin
                expect_sel = expect_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Misaddressed flits only raise the error; in-order and out-of-order flits are both counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data_reg  <= '0;
            rx_count_reg <= '0;
            rx_err_reg   <= 1'b0;
        end else if (rx_valid) begin
            if (!rx_dst_ok) begin
                rx_err_reg <= 1'b1;
            end else begin
                if (rx_payload != expect_sel) begin
                    rx_err_reg <= 1'b1;
                end
                rx_data_reg <= rx_payload;
                if (rx_count_reg != '1) begin
                    rx_count_reg <= rx_count_reg + CNT_W'(1);
                end
            end
        end
    end

    assign rx_data  = rx_data_reg;
    assign rx_count = rx_count_reg;
    assign rx_err   = rx_err_reg;

endmodule

// File: tb/tb_noc_pe_injector.sv
// Bench for noc_pe_injector: two instances at node 2 (GAP=0 and GAP=2) checked every cycle
// against a transaction-level model, plus hand-computed flit and pattern expectations.
`timescale 1ns/1ps
module tb_noc_pe_injector;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        cfg_valid [2];
    logic [1:0]  cfg_dest  [2];
    logic [8:0]  cfg_count [2];
    logic        cfg_ready [2];
    logic        cfg_err   [2];
    logic        block     [2];
    logic [11:0] tx_flit   [2];
    logic        tx_valid  [2];
    logic        tx_ready  [2];
    logic        done      [2];
    logic [11:0] rx_flit   [2];
    logic        rx_valid  [2];
    logic [7:0]  rx_data   [2];
    logic [8:0]  rx_count  [2];
    logic        rx_err    [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    generate
        for (genvar gk = 0; gk < 2; gk++) begin : g_dut
            noc_pe_injector #(
                .N_NODES(4), .NODE_ID(2), .DATA_W(8), .CNT_W(9), .GAP(gk * 2)
            ) u_dut (
                .clock(clock), .reset(reset),
                .cfg_valid(cfg_valid[gk]), .cfg_dest(cfg_dest[gk]), .cfg_count(cfg_count[gk]),
                .cfg_ready(cfg_ready[gk]), .cfg_err(cfg_err[gk]),
                .block_all_paths(block[gk]),
                .tx_flit(tx_flit[gk]), .tx_valid(tx_valid[gk]), .tx_ready(tx_ready[gk]),
                .done(done[gk]),
                .rx_flit(rx_flit[gk]), .rx_valid(rx_valid[gk]),
                .rx_data(rx_data[gk]), .rx_count(rx_count[gk]), .rx_err(rx_err[gk])
            );
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: flits still owed, idle cycles still owed, next sequence number.
    int       m_rem  [2] = '{0, 0};
    int       m_gap  [2] = '{0, 0};
    int       m_seq  [2] = '{0, 0};
    logic [1:0] m_dest [2] = '{2'd0, 2'd0};
    bit       m_done [2] = '{0, 0};
    bit       m_err  [2] = '{0, 0};
    int       m_tab  [2][4];
    int       m_rxc  [2] = '{0, 0};
    int       m_rxd  [2] = '{0, 0};
    bit       m_rxe  [2] = '{0, 0};

    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            bit e_valid, nd, ne;
            int src, dst, pl;
            if (reset) begin
                m_rem[k] = 0; m_gap[k] = 0; m_seq[k] = 0; m_dest[k] = 2'd0;
                m_done[k] = 0; m_err[k] = 0;
                for (int s = 0; s < 4; s++) m_tab[k][s] = 0;
                m_rxc[k] = 0; m_rxd[k] = 0; m_rxe[k] = 0;
            end
            e_valid = (m_rem[k] > 0) && (m_gap[k] == 0) && !block[k];
            check($sformatf("d%0d.cfg_ready", k), cfg_ready[k], !((m_rem[k] > 0) || m_done[k]));
            check($sformatf("d%0d.tx_valid", k), tx_valid[k], e_valid);
            check($sformatf("d%0d.done", k), done[k], m_done[k]);
            check($sformatf("d%0d.cfg_err", k), cfg_err[k], m_err[k]);
            check($sformatf("d%0d.rx_count", k), rx_count[k], m_rxc[k]);
            check($sformatf("d%0d.rx_data", k), rx_data[k], m_rxd[k]);
            check($sformatf("d%0d.rx_err", k), rx_err[k], m_rxe[k]);
            if (e_valid)
                check($sformatf("d%0d.tx_flit", k), tx_flit[k], {2'd2, m_dest[k], 8'(m_seq[k])});
            if (!reset) begin
                nd = 0; ne = 0;
                if (m_rem[k] > 0) begin
                    if (m_gap[k] > 0) begin
                        m_gap[k]--;
                    end else if (tx_ready[k] && !block[k]) begin
                        m_seq[k] = (m_seq[k] + 1) % 256;
                        m_rem[k]--;
                        if (m_rem[k] == 0) nd = 1;
                        else m_gap[k] = k * 2;
                    end
                end else if (!m_done[k] && cfg_valid[k]) begin
                    if (cfg_dest[k] == 2'd2) ne = 1;
                    else if (cfg_count[k] == 0) nd = 1;
                    else begin
                        m_rem[k] = int'(cfg_count[k]);
                        m_dest[k] = cfg_dest[k];
                        m_seq[k] = 0;
                    end
                end
                m_done[k] = nd;
                m_err[k] = ne;
                if (rx_valid[k]) begin
                    src = int'(rx_flit[k][11:10]);
                    dst = int'(rx_flit[k][9:8]);
                    pl  = int'(rx_flit[k][7:0]);
                    if (dst != 2) begin
                        m_rxe[k] = 1;
                    end else begin
                        if (pl != m_tab[k][src]) m_rxe[k] = 1;
                        m_tab[k][src] = (pl + 1) % 256;
                        m_rxd[k] = pl;
                        if (m_rxc[k] < 511) m_rxc[k]++;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_cfg(input int k, input logic [1:0] d, input int c);
        cfg_valid[k] = 1'b1;
        cfg_dest[k]  = d;
        cfg_count[k] = 9'(c);
        tick(1);
        cfg_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int lim);
        int n = 0;
        while (!done[k] && n < lim) begin
            tick(1);
            n++;
        end
        check($sformatf("d%0d.wait_done", k), done[k], 1);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        int xf, idx, n;
        logic [11:0] rxv [3];
        logic rdy_tab [8];
        logic blk_tab [8];
        rxv = '{12'h600, 12'h601, 12'h603};
        rdy_tab = '{1, 0, 0, 1, 1, 1, 1, 1};
        blk_tab = '{0, 0, 0, 0, 1, 1, 0, 0};
        for (int k = 0; k < 2; k++) begin
            cfg_valid[k] = 0; cfg_dest[k] = 0; cfg_count[k] = 0; block[k] = 0;
            tx_ready[k] = 1; rx_flit[k] = 0; rx_valid[k] = 0;
        end

        tick(2);
        reset = 1'b0;
        tick(1);
        $display("reset released");
        check("reset.cfg_ready", cfg_ready[0], 1);
        check("reset.tx_flit", tx_flit[0], 0);

        send_cfg(0, 2'd3, 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("burst3.valid%0d", i), tx_valid[0], 1);
            check($sformatf("burst3.flit%0d", i), tx_flit[0], 12'hB00 + 12'(i));
            $display("burst3 flit %0d = %h", i, tx_flit[0]);
            tick(1);
        end
        check("burst3.done", done[0], 1);
        tick(1);
        check("burst3.ready_back", cfg_ready[0], 1);

        send_cfg(0, 2'd1, 4);
        xf = 0;
        for (int i = 0; i < 8; i++) begin
            tx_ready[0] = rdy_tab[i];
            block[0] = blk_tab[i];
            #1;
            if (i == 2) check("bp.held_flit", tx_flit[0], 12'h901);
            if (tx_valid[0] && tx_ready[0] && !block[0]) xf++;
            $display("bp cycle %0d rdy=%0b blk=%0b valid=%0b flit=%h", i, tx_ready[0], block[0], tx_valid[0], tx_flit[0]);
            tick(1);
        end
        tx_ready[0] = 1; block[0] = 0;
        check("bp.transfers", xf, 4);
        wait_done(0, 10);

        send_cfg(1, 2'd0, 4);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            pat = {pat[8:0], tx_valid[1]};
            tick(1);
        end
        $display("gap pattern %b", pat);
        check("gap.pattern", pat, 10'b1001001001);
        check("gap.done", done[1], 1);
        tick(1);

        send_cfg(0, 2'd2, 5);
        $display("reject own dest");
        check("rej.cfg_err", cfg_err[0], 1);
        check("rej.tx_valid", tx_valid[0], 0);
        tick(1);
        check("rej.err_clear", cfg_err[0], 0);
        send_cfg(0, 2'd1, 0);
        $display("zero count");
        check("zero.done", done[0], 1);
        check("zero.tx_valid", tx_valid[0], 0);
        tick(1);
        check("zero.done_clear", done[0], 0);
        send_cfg(0, 2'd3, 2);
        cfg_valid[0] = 1; cfg_dest[0] = 2'd2; cfg_count[0] = 9'd7;
        tick(2);
        cfg_valid[0] = 0;
        $display("cfg during send ignored");
        check("ign.cfg_err", cfg_err[0], 0);
        check("ign.done", done[0], 1);
        tick(1);

        send_cfg(0, 2'd3, 3);
        for (int i = 0; i < 3; i++) begin
            rx_flit[0] = rxv[i];
            rx_valid[0] = 1;
            $display("rx flit %h", rxv[i]);
            tick(1);
        end
        rx_valid[0] = 0;
        check("rx.count", rx_count[0], 3);
        check("rx.data", rx_data[0], 3);
        check("rx.err", rx_err[0], 1);
        wait_done(0, 5);
        rx_flit[1] = 12'h704;
        rx_valid[1] = 1;
        tick(1);
        rx_valid[1] = 0;
        $display("rx wrong dest on d1");
        check("rxdst.count", rx_count[1], 0);
        check("rxdst.err", rx_err[1], 1);

        send_cfg(0, 2'd3, 5);
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        $display("async reset mid-burst");
        check("rst.tx_valid", tx_valid[0], 0);
        check("rst.cfg_ready", cfg_ready[0], 1);
        tick(1);
        reset = 1'b0;
        tick(1);
        send_cfg(0, 2'd1, 2);
        check("rst.restart_flit", tx_flit[0], 12'h900);
        wait_done(0, 5);

        send_cfg(0, 2'd3, 257);
        idx = 0; n = 0;
        while (!done[0] && n < 400) begin
            if (tx_valid[0]) begin
                if (idx == 255) check("wrap.seq255", tx_flit[0], 12'hBFF);
                if (idx == 256) check("wrap.seq0", tx_flit[0], 12'hB00);
                idx++;
            end
            tick(1);
            n++;
        end
        $display("wrap burst transfers %0d", idx);
        check("wrap.count", idx, 257);
        check("wrap.done", done[0], 1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
